ap_wall_final_add: RTL and testbench
====================================

// Module: ap_wall_final_add
// PURPOSE
//  Final stage of the approximate 4x4 unsigned Wallace multiplier: takes the two
//  reduced rows (sum, carry) from the approximate compressor tree, adds them in a
//  carry-propagate adder and delivers the product through a 2-entry
//  valid/ready output buffer.
//  Sits directly downstream of the compressor tree and upstream of the result consumer.
//  Optional monitor counts approximation errors against the exact product.
// PARAMETERS
//  W      8   row/product width in bits (2x operand width)
//  OPW    4   operand width, used only by the error monitor
//  ECNT_W 16  width of the error counters (saturating)
// PORTS
//  clk        in   1       clock; all state updates on rising edge
//  rst_n      in   1       synchronous reset, active low
//  in_valid   in   1       row pair valid
//  in_ready   out  1       block can accept a row pair this cycle
//  row_s      in   W       sum row from compressor tree
//  row_c      in   W       carry row from compressor tree, already weight-aligned
//  op_a       in   OPW     original multiplicand (sideband, monitor only)
//  op_b       in   OPW     original multiplier (sideband, monitor only)
//  out_valid  out  1       product valid
//  out_ready  in   1       consumer accepts product
//  prod       out  W       (row_s + row_c) mod 2^W
//  ovf        out  1       carry-out of the W-bit add, travels with prod
//  err_clr    in   1       clears error counters (monitor only)
//  err_cnt    out  ECNT_W  number of delivered products != op_a*op_b
//  err_sum    out  ECNT_W  accumulated |prod - op_a*op_b|
// BEHAVIOUR
//  - Accept when in_valid & in_ready; deliver when out_valid & out_ready.
//  - Adder is combinational on the inputs; the W+1-bit result {ovf, prod} plus
//    op_a/op_b is written into the buffer on accept.
//  - Buffer: 2 entries, FIFO order, occupancy cnt in 0..2.
//    in_ready = (cnt != 2), a registered-state function with no comb path from out_ready.
//    out_valid = (cnt != 0); prod and ovf show the head entry and are held stable while out_valid & !out_ready.
//  - Latency: accept in cycle N -> out_valid in cycle N+1 when the buffer was empty.
//  - Push and pop in the same cycle: cnt unchanged and order preserved;
//    at cnt 1 the new entry becomes head in the next cycle.
//  - cnt 2: in_ready=0, so no push is possible; pop -> cnt 1, and in_ready=1 in the next cycle.
//  - Reset (rst_n=0 at clk edge): cnt=0, out_valid=0, in_ready=1, prod=0, ovf=0,
//    err_cnt=0, err_sum=0. A mid-operation reset drops all buffered entries and never emits them.
//  - Widths: the sum is W+1 bits and is never sign-extended (all operands unsigned).
// CONFIGURATION
//  AP_ERR_MON_EN defined:
//   - On each deliver, exact = op_a*op_b (2*OPW bits) is compared against prod.
//   - When they differ, err_cnt += 1 and err_sum += |prod - exact|.
//   - Both counters saturate at all-ones.
//   - err_clr zeroes both counters in the next cycle and has priority over a
//     same-cycle update.
//  AP_ERR_MON_EN undefined:
//   - err_cnt and err_sum are tied to 0; err_clr, op_a and op_b are ignored.
//   - No sideband storage in the buffer.
// TESTING
//  1. Reset, then row_s=8'h05, row_c=8'h04, out_ready=1 -> next cycle out_valid=1, prod=8'h09, ovf=0.
//  2. row_s=8'hFF, row_c=8'h01 -> prod=8'h00, ovf=1.
//  3. out_ready=0, push 3 pairs (sums 1,2,3) -> in_ready=0 after 2 accepts;
//     3rd not accepted; release out_ready -> 1,2 then 3 delivered in order.
//  4. cnt=1 with simultaneous push and pop for 10 cycles -> one product delivered per cycle,
//     in_ready stays 1, no loss or duplication.
//  5. rst_n=0 with cnt=2 -> next cycle out_valid=0, in_ready=1, prod=0; old entries never appear.
//  6. AP_ERR_MON_EN: op_a=3, op_b=3, rows giving prod=8 -> err_cnt=1, err_sum=1;
//     drive err_cnt to all-ones -> holds; err_clr -> 0.

Source files
------------

// File: rtl/ap_wall_final_add_if.sv
// Handshake bundle between the compressor tree, the final adder and the result consumer.
// master: upstream/downstream environment side; slave: ap_wall_final_add side.
interface ap_wall_final_add_if #(
  parameter int W   = 8,
  parameter int OPW = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   row_s;
  logic [W-1:0]   row_c;
  logic [OPW-1:0] op_a;
  logic [OPW-1:0] op_b;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   prod;
  logic           ovf;

  modport master (
    output in_valid, row_s, row_c, op_a, op_b, out_ready,
    input  in_ready, out_valid, prod, ovf
  );

  modport slave (
    input  in_valid, row_s, row_c, op_a, op_b, out_ready,
    output in_ready, out_valid, prod, ovf
  );
endinterface

// File: rtl/ap_wall_final_add.sv
// Final carry-propagate add of the approximate 4x4 Wallace multiplier, followed by
// a 2-entry valid/ready FIFO holding {ovf, prod}.
// Optional error monitor enabled by defining AP_ERR_MON_EN: counts delivered
// products that differ from op_a*op_b and accumulates the absolute error
// (both counters saturating). Without it, err_cnt/err_sum are tied to 0.
module ap_wall_final_add #(
  parameter int W      = 8,
  parameter int OPW    = 4,
  parameter int ECNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ap_wall_final_add_if.slave   bus,
  input  logic                 err_clr,
  output logic [ECNT_W-1:0]    err_cnt,
  output logic [ECNT_W-1:0]    err_sum
);

`ifdef AP_ERR_MON_EN
  localparam int ENT_W = W + 1 + 2*OPW;
`else
  localparam int ENT_W = W + 1;
`endif

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t             occ;
  occ_t             occ_nxt;
  logic             in_rdy_q;
  logic             out_vld_q;
  logic             rd_ptr;
  logic             wr_ptr;
  logic             push;
  logic             pop;
  logic [W:0]       sum;
  logic [ENT_W-1:0] entry_in;
  logic [ENT_W-1:0] head;
  logic [ENT_W-1:0] mem [2];

  assign push = bus.in_valid & in_rdy_q;
  assign pop  = out_vld_q & bus.out_ready;

  // Carry-propagate add of the two reduced rows, zero-extended to W+1 bits.
  always_comb begin
    sum = {1'b0, bus.row_s} + {1'b0, bus.row_c};
`ifdef AP_ERR_MON_EN
    entry_in = {bus.op_a, bus.op_b, sum};
`else
    entry_in = sum;
`endif
  end

  // Occupancy next-state; a push at FULL cannot happen because in_ready is low.
  always_comb begin
    occ_nxt = occ;
    case (occ)
      EMPTY:   if (push) occ_nxt = ONE;
      ONE:     if (push && !pop) occ_nxt = FULL;
               else if (!push && pop) occ_nxt = EMPTY;
      FULL:    if (pop) occ_nxt = ONE;
      default: occ_nxt = EMPTY;
    endcase
  end

  // Buffer state, pointers and registered in_ready/out_valid decoded from next occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ       <= EMPTY;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      mem[0]    <= '0;
      mem[1]    <= '0;
    end else begin
      occ       <= occ_nxt;
      in_rdy_q  <= (occ_nxt != FULL);
      out_vld_q <= (occ_nxt != EMPTY);
      if (push) begin
        mem[wr_ptr] <= entry_in;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  assign head          = mem[rd_ptr];
  assign bus.in_ready  = in_rdy_q;
  assign bus.out_valid = out_vld_q;
  assign bus.prod      = head[W-1:0];
  assign bus.ovf       = head[W];

`ifdef AP_ERR_MON_EN
  localparam int XW = 2*OPW;
  localparam int MW = (W > XW) ? W : XW;
  localparam int SW = ((MW > ECNT_W) ? MW : ECNT_W) + 1;

  logic [OPW-1:0]    h_a;
  logic [OPW-1:0]    h_b;
  logic [XW-1:0]     exact;
  logic [MW-1:0]     p_ext;
  logic [MW-1:0]     x_ext;
  logic [MW-1:0]     diff;
  logic [SW-1:0]     sum_wide;
  logic [ECNT_W-1:0] sum_sat;
  logic              mismatch;

  // Exact product of the head entry's operands and the saturated error accumulation.
  always_comb begin
    h_b      = head[W+1 +: OPW];
    h_a      = head[W+1+OPW +: OPW];
    exact    = {{OPW{1'b0}}, h_a} * {{OPW{1'b0}}, h_b};
    p_ext    = MW'(head[W-1:0]);
    x_ext    = MW'(exact);
    mismatch = (p_ext != x_ext);
    diff     = (p_ext >= x_ext) ? (p_ext - x_ext) : (x_ext - p_ext);
    sum_wide = SW'(err_sum) + SW'(diff);
    sum_sat  = (sum_wide > SW'({ECNT_W{1'b1}})) ? '1 : sum_wide[ECNT_W-1:0];
  end

  // Error counters: clear wins over a same-cycle update, both saturate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
      err_sum <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
      err_sum <= '0;
    end else if (pop && mismatch) begin
      if (err_cnt != '1) err_cnt <= err_cnt + ECNT_W'(1);
      err_sum <= sum_sat;
    end
  end
`else
  logic unused_mon;
  assign unused_mon = ^{err_clr, bus.op_a, bus.op_b};
  assign err_cnt    = '0;
  assign err_sum    = '0;
`endif

endmodule

// File: tb/tb_ap_wall_final_add.sv
// Scoreboard bench for ap_wall_final_add: expected results are queued on accept
// and compared by a negedge monitor on deliver. Define AP_ERR_MON_EN for the monitor tests.
module tb_ap_wall_final_add;
  localparam int W    = 8;
  localparam int OPW  = 4;
  localparam int ECW  = 6;
  localparam int MAXC = (1 << ECW) - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           err_clr = 1'b0;
  logic [ECW-1:0] err_cnt;
  logic [ECW-1:0] err_sum;

  always #5 clk = ~clk;

  ap_wall_final_add_if #(.W(W), .OPW(OPW)) bus ();

  ap_wall_final_add #(.W(W), .OPW(OPW), .ECNT_W(ECW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .err_clr (err_clr),
    .err_cnt (err_cnt),
    .err_sum (err_sum)
  );

  typedef struct { int res; int a; int b; } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;
  int m_cnt = 0;
  int m_sum = 0;
  int pops  = 0;
  bit live  = 0;

  function automatic void check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor / scoreboard / error-counter reference model
  always @(negedge clk) begin
    exp_t       e;
    logic [8:0] got;
    int         ex, pr, d;
    if (live) begin
      check("err_cnt", int'(err_cnt), m_cnt);
      check("err_sum", int'(err_sum), m_sum);
    end
    if (!rst_n) begin
      sb.delete();
      m_cnt = 0;
      m_sum = 0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        pops++;
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e   = sb.pop_front();
          got = {bus.ovf, bus.prod};
          check("product", int'(got), e.res);
`ifdef AP_ERR_MON_EN
          ex = e.a * e.b;
          pr = e.res % 256;
          if (pr != ex) begin
            d = (pr > ex) ? pr - ex : ex - pr;
            m_cnt = (m_cnt + 1 > MAXC) ? MAXC : m_cnt + 1;
            m_sum = (m_sum + d > MAXC) ? MAXC : m_sum + d;
          end
`endif
        end
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back('{res: int'(bus.row_s) + int'(bus.row_c),
                       a: int'(bus.op_a), b: int'(bus.op_b)});
      if (err_clr) begin
        m_cnt = 0;
        m_sum = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one row pair and hold it until accepted (bounded).
  task automatic send(input int s, input int c, input int a, input int b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.row_s    = W'(s);
    bus.row_c    = W'(c);
    bus.op_a     = OPW'(a);
    bus.op_b     = OPW'(b);
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 50) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  p0;
    bit  acc;
    bus.in_valid  = 1'b0;
    bus.row_s     = '0;
    bus.row_c     = '0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    tick();
    live = 1;
    tick();
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_in_ready",  int'(bus.in_ready), 1);
    check("rst_prod",      int'(bus.prod), 0);
    check("rst_ovf",       int'(bus.ovf), 0);
    rst_n = 1'b1;
    tick();

    // Basic add with one-cycle latency
    bus.out_ready = 1'b1;
    send(8'h05, 8'h04, 0, 0);
    check("t1_out_valid", int'(bus.out_valid), 1);
    check("t1_prod",      int'(bus.prod), 9);
    check("t1_ovf",       int'(bus.ovf), 0);
    tick();

    // Carry out of the W-bit add
    send(8'hFF, 8'h01, 0, 0);
    check("t2_prod", int'(bus.prod), 0);
    check("t2_ovf",  int'(bus.ovf), 1);
    repeat (2) tick();

    // Fill to two entries with backpressure; third must wait
    bus.out_ready = 1'b0;
    send(1, 0, 0, 0);
    send(2, 0, 0, 0);
    check("t3_full_in_ready", int'(bus.in_ready), 0);
    bus.in_valid = 1'b1;
    bus.row_s    = 8'd3;
    bus.row_c    = 8'd0;
    repeat (3) begin
      @(negedge clk);
      check("t3_held_in_ready", int'(bus.in_ready), 0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(3, 0, 0, 0);
    repeat (4) tick();
    check("t3_drained", sb.size(), 0);

    // Simultaneous push and pop at one entry
    bus.out_ready = 1'b0;
    send(10, 0, 0, 0);
    bus.out_ready = 1'b1;
    p0 = pops;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.row_s    = W'(20 + i);
      bus.row_c    = W'(i);
      @(negedge clk);
      check("t4_in_ready",  int'(bus.in_ready), 1);
      check("t4_out_valid", int'(bus.out_valid), 1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check("t4_pops", pops - p0, 10);
    repeat (3) tick();
    check("t4_drained", sb.size(), 0);

    // Reset with a full buffer drops both entries
    bus.out_ready = 1'b0;
    send(7, 7, 1, 1);
    send(8, 8, 2, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_out_valid", int'(bus.out_valid), 0);
    check("t5_in_ready",  int'(bus.in_ready), 1);
    check("t5_prod",      int'(bus.prod), 0);
    check("t5_ovf",       int'(bus.ovf), 0);
    check("t5_err_cnt",   int'(err_cnt), 0);
    check("t5_err_sum",   int'(err_sum), 0);
    bus.out_ready = 1'b1;
    repeat (4) tick();

`ifdef AP_ERR_MON_EN
    // Error monitor: single error, saturation, clear
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    send(5, 3, 3, 3);
    repeat (2) tick();
    check("t6_err_cnt", int'(err_cnt), 1);
    check("t6_err_sum", int'(err_sum), 1);
    for (int i = 0; i < 70; i++) send(255, 0, 0, 0);
    repeat (3) tick();
    check("t6_sat_cnt", int'(err_cnt), MAXC);
    check("t6_sat_sum", int'(err_sum), MAXC);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t6_clr_cnt", int'(err_cnt), 0);
    check("t6_clr_sum", int'(err_sum), 0);
`endif

    // Randomized traffic, data held while not accepted
    acc = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!bus.in_valid || acc) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.row_s    = W'($urandom);
        bus.row_c    = W'($urandom);
        bus.op_a     = OPW'($urandom);
        bus.op_b     = OPW'($urandom);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      err_clr       = ($urandom_range(0, 31) == 0);
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    err_clr       = 1'b0;
    repeat (5) tick();
    check("final_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
